// File: rtl/axi_adc_jesd204_pnmon_pkg.sv
// Shared constants and types for the JESD204 ADC PN monitor.
package axi_adc_jesd204_pnmon_pkg;

    // PN9: x^9 + x^5 + 1, PN23: x^23 + x^18 + 1 (ITU-T O.150, uninverted)
    localparam int unsigned PN9_WIDTH  = 9;
    localparam int unsigned PN9_TAP    = 5;
    localparam int unsigned PN23_WIDTH = 23;
    localparam int unsigned PN23_TAP   = 18;

    // Error counter holds here instead of wrapping
    localparam logic [31:0] PN_ERR_CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic {
        PN_OOS    = 1'b0,
        PN_LOCKED = 1'b1
    } pn_state_t;

endpackage

// File: rtl/axi_adc_jesd204_pnstep.sv
// Combinational PN generator: continues the selected PN sequence from the
// last 9/23 stream bits of a seed beat and returns the next full beat.
// Stream order: samples in index order, each sample MSB first.
module axi_adc_jesd204_pnstep
    import axi_adc_jesd204_pnmon_pkg::*;
#(
    parameter int DATA_PATH_WIDTH = 4
) (
    input  logic                          pnseq_sel,
    input  logic [DATA_PATH_WIDTH*16-1:0] seed,
    output logic [DATA_PATH_WIDTH*16-1:0] pn_data
);

    localparam int unsigned BW = DATA_PATH_WIDTH * 16;
    localparam int unsigned HW = PN23_WIDTH + BW;

    // Stream position p lives at bit (p/16)*16 + 15 - p%16 of a beat.
    // h[] holds the stream in time order: 23 seed bits followed by BW new bits.
    function automatic logic [BW-1:0] pn_next(input logic [BW-1:0] seed_beat,
                                              input logic          sel);
        logic [HW-1:0] h;
        logic [BW-1:0] beat;
        int unsigned   p;
        int unsigned   n;
        h    = '0;
        beat = '0;
        for (int unsigned k = 0; k < PN23_WIDTH; k++) begin
            p    = BW - PN23_WIDTH + k;
            h[k] = seed_beat[(p / 16) * 16 + 15 - (p % 16)];
        end
        for (int unsigned k = 0; k < BW; k++) begin
            n = PN23_WIDTH + k;
            if (sel) h[n] = h[n - PN23_WIDTH] ^ h[n - PN23_TAP];
            else     h[n] = h[n - PN9_WIDTH]  ^ h[n - PN9_TAP];
            beat[(k / 16) * 16 + 15 - (k % 16)] = h[n];
        end
        return beat;
    endfunction

    // Expected next beat from the current seed
    always_comb begin
        pn_data = pn_next(seed, pnseq_sel);
    end

endmodule

// File: rtl/axi_adc_jesd204_pnmon.sv
// JESD204 ADC PN monitor: checks received beats against PN9/PN23, tracks
// lock with a run counter and counts mismatched beats while locked.
// Stage 1 registers the per-beat match flag, stage 2 updates state/counters.
module axi_adc_jesd204_pnmon
    import axi_adc_jesd204_pnmon_pkg::*;
#(
    parameter int DATA_PATH_WIDTH = 4,
    parameter int OOS_THRESHOLD   = 16
) (
    input  logic                          adc_clk,
    input  logic                          adc_rst,
    input  logic                          adc_valid,
    input  logic [DATA_PATH_WIDTH*16-1:0] adc_data,
    input  logic                          adc_pnseq_sel,
    input  logic                          adc_pn_err_clr,
    output logic                          adc_pn_oos,
    output logic                          adc_pn_err,
    output logic [31:0]                   adc_pn_err_cnt
);

    localparam int unsigned BW       = DATA_PATH_WIDTH * 16;
    localparam logic [7:0]  RUN_LAST = 8'(OOS_THRESHOLD - 1);

    logic [BW-1:0] seed_q;
    logic [BW-1:0] pn_exp;
    logic          seeded_q;
    logic          sel_q;
    logic          sel_chg;
    logic          beat_match;
    logic          s1_valid_q;
    logic          s1_match_q;

    pn_state_t     state_q, state_nxt;
    logic [7:0]    run_q, run_nxt;
    logic          err_q, err_nxt;
    logic [31:0]   err_cnt_q, err_cnt_nxt;

    axi_adc_jesd204_pnstep #(
        .DATA_PATH_WIDTH(DATA_PATH_WIDTH)
    ) i_pnstep (
        .pnseq_sel (adc_pnseq_sel),
        .seed      (seed_q),
        .pn_data   (pn_exp)
    );

    assign sel_chg    = (adc_pnseq_sel != sel_q);
    assign beat_match = seeded_q && (adc_data == pn_exp) && (adc_data != '0);

    // Stage 1: register match flag and advance the seed on each valid beat.
    // A sequence change restarts seeding; a beat arriving with it becomes the seed.
    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            seed_q     <= '0;
            seeded_q   <= 1'b0;
            sel_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_match_q <= 1'b0;
        end else begin
            sel_q      <= adc_pnseq_sel;
            s1_valid_q <= adc_valid && !sel_chg;
            if (sel_chg) begin
                s1_match_q <= 1'b0;
                seeded_q   <= adc_valid;
                if (adc_valid) seed_q <= adc_data;
            end else if (adc_valid) begin
                s1_match_q <= beat_match;
                seeded_q   <= 1'b1;
                seed_q     <= (state_q == PN_OOS) ? adc_data : pn_exp;
            end
        end
    end

    // Stage 2 registers: lock state, run counter, error pulse and count
    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            state_q   <= PN_OOS;
            run_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_nxt;
            run_q     <= run_nxt;
            err_q     <= err_nxt;
            err_cnt_q <= err_cnt_nxt;
        end
    end

    // Stage 2 next-state: count match runs in OOS, mismatch runs in LOCKED
    always_comb begin
        state_nxt   = state_q;
        run_nxt     = run_q;
        err_nxt     = 1'b0;
        err_cnt_nxt = err_cnt_q;
        if (sel_chg) begin
            state_nxt = PN_OOS;
            run_nxt   = '0;
        end else if (s1_valid_q) begin
            if (state_q == PN_OOS) begin
                if (!s1_match_q) begin
                    run_nxt = '0;
                end else if (run_q == RUN_LAST) begin
                    state_nxt = PN_LOCKED;
                    run_nxt   = '0;
                end else begin
                    run_nxt = run_q + 8'd1;
                end
            end else begin
                if (s1_match_q) begin
                    run_nxt = '0;
                end else begin
                    err_nxt = 1'b1;
                    if (err_cnt_q != PN_ERR_CNT_MAX) err_cnt_nxt = err_cnt_q + 32'd1;
                    if (run_q == RUN_LAST) begin
                        state_nxt = PN_OOS;
                        run_nxt   = '0;
                    end else begin
                        run_nxt = run_q + 8'd1;
                    end
                end
            end
        end
        if (adc_pn_err_clr) err_cnt_nxt = '0;
    end

    assign adc_pn_oos     = (state_q == PN_OOS);
    assign adc_pn_err     = err_q;
    assign adc_pn_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_axi_adc_jesd204_pnmon.sv
// Self-checking bench for axi_adc_jesd204_pnmon (DATA_PATH_WIDTH=4, threshold 16).
module tb_axi_adc_jesd204_pnmon;

    localparam int DPW = 4;
    localparam int TH  = 16;
    localparam int BW  = DPW * 16;
    typedef logic [BW-1:0] beat_t;

    logic        adc_clk = 1'b0;
    logic        adc_rst = 1'b1;
    logic        adc_valid = 1'b0;
    beat_t       adc_data = '0;
    logic        adc_pnseq_sel = 1'b0;
    logic        adc_pn_err_clr = 1'b0;
    logic        adc_pn_oos;
    logic        adc_pn_err;
    logic [31:0] adc_pn_err_cnt;

    int checks = 0;
    int failures = 0;
    int pulses = 0;

    // reference model state
    bit        m_locked, m_sel, m_seeded, m_err;
    int        m_run;
    bit [31:0] m_cnt;
    beat_t     m_seed;
    bit        m_pend[$];

    beat_t src;  // last beat emitted by the PN source

    typedef struct {
        int n_good;
        int n_bad;
        bit clr;
        bit exp_oos;
        int exp_cnt;
        int exp_pulses;
    } row_t;
    row_t rows[9];

    always #5 adc_clk = ~adc_clk;

    axi_adc_jesd204_pnmon #(
        .DATA_PATH_WIDTH(DPW),
        .OOS_THRESHOLD(TH)
    ) dut (
        .adc_clk        (adc_clk),
        .adc_rst        (adc_rst),
        .adc_valid      (adc_valid),
        .adc_data       (adc_data),
        .adc_pnseq_sel  (adc_pnseq_sel),
        .adc_pn_err_clr (adc_pn_err_clr),
        .adc_pn_oos     (adc_pn_oos),
        .adc_pn_err     (adc_pn_err),
        .adc_pn_err_cnt (adc_pn_err_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Serialise the beat to a bit list, extend it by the recurrence, rebuild a beat
    function automatic beat_t pn_model(input beat_t prev, input bit sel);
        int    len = sel ? 23 : 9;
        int    tap = sel ? 18 : 5;
        bit    s[$];
        beat_t b = '0;
        int    p = BW;
        for (int i = 0; i < DPW; i++)
            for (int j = 15; j >= 0; j--) s.push_back(prev[i*16+j]);
        for (int n = 0; n < BW; n++) s.push_back(s[s.size()-len] ^ s[s.size()-tap]);
        for (int i = 0; i < DPW; i++)
            for (int j = 15; j >= 0; j--) begin
                b[i*16+j] = s[p];
                p++;
            end
        return b;
    endfunction

    task automatic m_reset();
        m_locked = 0; m_sel = 0; m_seeded = 0; m_err = 0;
        m_run = 0; m_cnt = 0; m_seed = '0;
        m_pend.delete();
    endtask

    // One clock of the reference: verdicts take effect one clock after acceptance
    task automatic m_step(input bit valid, input beat_t data, input bit sel, input bit clr);
        bit    was_locked;
        bit    verdict;
        beat_t e;
        was_locked = m_locked;
        m_err = 0;
        if (sel != m_sel) begin
            m_sel = sel; m_locked = 0; m_run = 0;
            m_pend.delete();
            m_seeded = valid;
            if (valid) m_seed = data;
            if (clr) m_cnt = 0;
            return;
        end
        if (m_pend.size() > 0) begin
            verdict = m_pend.pop_front();
            if (!m_locked) begin
                m_run = verdict ? m_run + 1 : 0;
                if (m_run == TH) begin m_locked = 1; m_run = 0; end
            end else begin
                m_run = verdict ? 0 : m_run + 1;
                if (!verdict) begin
                    m_err = 1;
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
                end
                if (m_run == TH) begin m_locked = 0; m_run = 0; end
            end
        end
        if (clr) m_cnt = 0;
        if (valid) begin
            e = pn_model(m_seed, sel);
            m_pend.push_back(m_seeded && data == e && data != '0);
            m_seed = was_locked ? e : data;
            m_seeded = 1;
        end
    endtask

    // Advance one clock, step the model, compare on the falling edge
    task automatic tick();
        @(posedge adc_clk);
        if (adc_rst) m_reset();
        else m_step(adc_valid, adc_data, adc_pnseq_sel, adc_pn_err_clr);
        @(negedge adc_clk);
        if (adc_pn_err === 1'b1) pulses++;
        check("cyc_oos", {31'd0, adc_pn_oos}, {31'd0, !m_locked});
        check("cyc_err", {31'd0, adc_pn_err}, {31'd0, m_err});
        check("cyc_cnt", adc_pn_err_cnt, m_cnt);
    endtask

    // kind: 0 correct PN, 1 correct with bit 0 flipped, 2 zero, 3 random, 4 idle
    task automatic send(input int kind);
        if (kind == 4) begin
            adc_valid = 1'b0;
        end else begin
            adc_valid = 1'b1;
            if (kind <= 1) begin
                src = pn_model(src, adc_pnseq_sel);
                adc_data = src;
                if (kind == 1) adc_data[0] = ~adc_data[0];
            end else if (kind == 2) begin
                adc_data = '0;
            end else begin
                for (int w = 0; w < BW / 32; w++) adc_data[w*32 +: 32] = $urandom;
            end
        end
        tick();
    endtask

    task automatic apply_reset();
        adc_rst = 1'b1;
        adc_valid = 1'b0;
        adc_pn_err_clr = 1'b0;
        adc_pnseq_sel = 1'b0;
        src = '1;
        tick();
        tick();
        adc_rst = 1'b0;
    endtask

    task automatic lock_pn9();
        for (int k = 0; k < 17; k++) send(0);
        send(4);
        send(4);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        rows[0] = '{0, 1, 0, 0, 1, 1};
        rows[1] = '{3, 0, 0, 0, 1, 0};
        rows[2] = '{0, 15, 0, 0, 16, 15};
        rows[3] = '{1, 0, 0, 0, 16, 0};
        rows[4] = '{0, 16, 0, 1, 32, 16};
        rows[5] = '{0, 1, 0, 1, 32, 0};
        rows[6] = '{15, 0, 0, 1, 32, 0};
        rows[7] = '{1, 0, 0, 0, 32, 0};
        rows[8] = '{0, 0, 1, 0, 0, 0};

        m_reset();
        apply_reset();
        check("rst_oos", {31'd0, adc_pn_oos}, 32'd1);
        check("rst_err", {31'd0, adc_pn_err}, 32'd0);
        check("rst_cnt", adc_pn_err_cnt, 32'd0);

        // Clean PN9 lock from seed 0x1FF: beat 1 seeds, beats 2..17 match
        for (int k = 0; k < 17; k++) send(0);
        check("lock_early_oos", {31'd0, adc_pn_oos}, 32'd1);
        send(4);
        check("lock_oos", {31'd0, adc_pn_oos}, 32'd0);
        check("lock_cnt", adc_pn_err_cnt, 32'd0);

        // Table of locked-state sequences, each followed by two idle clocks
        foreach (rows[i]) begin
            pulses = 0;
            if (rows[i].clr) begin
                adc_pn_err_clr = 1'b1;
                send(4);
                adc_pn_err_clr = 1'b0;
            end
            for (int k = 0; k < rows[i].n_good; k++) send(0);
            for (int k = 0; k < rows[i].n_bad; k++) send(1);
            send(4);
            send(4);
            check($sformatf("row%0d_oos", i), {31'd0, adc_pn_oos}, {31'd0, rows[i].exp_oos});
            check($sformatf("row%0d_cnt", i), adc_pn_err_cnt, rows[i].exp_cnt);
            check($sformatf("row%0d_pulses", i), pulses, rows[i].exp_pulses);
        end

        // Loss of sync with 16 random beats
        for (int k = 0; k < 16; k++) send(3);
        send(4);
        send(4);
        check("los_oos", {31'd0, adc_pn_oos}, 32'd1);
        check("los_cnt", adc_pn_err_cnt, 32'd16);

        // All-zero data never locks
        apply_reset();
        for (int k = 0; k < 40; k++) send(2);
        send(4);
        send(4);
        check("zero_oos", {31'd0, adc_pn_oos}, 32'd1);

        // PN23 with gaps: 17 valid beats interleaved with idle clocks
        apply_reset();
        adc_pnseq_sel = 1'b1;
        for (int k = 0; k < 17; k++) begin
            send(0);
            if (k == 16) check("pn23_early_oos", {31'd0, adc_pn_oos}, 32'd1);
            send(4);
        end
        check("pn23_oos", {31'd0, adc_pn_oos}, 32'd0);

        // Async reset between edges while locked with a nonzero count
        send(1);
        send(4);
        check("ar_pre_cnt", adc_pn_err_cnt, 32'd1);
        #2 adc_rst = 1'b1;
        #1;
        check("ar_oos", {31'd0, adc_pn_oos}, 32'd1);
        check("ar_err", {31'd0, adc_pn_err}, 32'd0);
        check("ar_cnt", adc_pn_err_cnt, 32'd0);
        apply_reset();

        // Saturation from a preloaded count
        lock_pn9();
        force dut.err_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.err_cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) send(1);
        send(4);
        send(4);
        check("sat_cnt", adc_pn_err_cnt, 32'hFFFF_FFFF);

        // Clear colliding with an increment
        send(1);
        adc_pn_err_clr = 1'b1;
        send(4);
        adc_pn_err_clr = 1'b0;
        check("clr_col_err", {31'd0, adc_pn_err}, 32'd1);
        check("clr_col_cnt", adc_pn_err_cnt, 32'd0);

        // Sequence select change forces OOS on the next clock, count kept
        send(1);
        send(4);
        check("sel_pre_oos", {31'd0, adc_pn_oos}, 32'd0);
        adc_pnseq_sel = 1'b1;
        send(4);
        check("sel_oos", {31'd0, adc_pn_oos}, 32'd1);
        check("sel_cnt", adc_pn_err_cnt, 32'd1);

        // Randomised traffic against the reference model
        apply_reset();
        for (int c = 0; c < 2500; c++) begin
            r = $urandom_range(0, 999);
            if (r < 4) adc_pnseq_sel = ~adc_pnseq_sel;
            adc_pn_err_clr = ($urandom_range(0, 59) == 0);
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 299) == 0) begin
                adc_pn_err_clr = 1'b0;
                for (int k = 0; k < 20; k++) send(3);
            end else if (r < 85) send(0);
            else if (r < 89) send(1);
            else if (r < 90) send(2);
            else if (r < 92) send(3);
            else send(4);
        end
        adc_pn_err_clr = 1'b0;
        send(4);
        send(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_adc_jesd204_pnmon.md
AXI_ADC_JESD204_PNMON -- requirements
Module: axi_adc_jesd204_pnmon

Interface
REQ-001 Parameter DATA_PATH_WIDTH, default 4, meaning 16-bit samples per beat; the legal values SHALL be 2, 4 and 8.
REQ-002 Parameter OOS_THRESHOLD, default 16, meaning consecutive beats needed to lock or unlock; the legal range SHALL be 2..255.
REQ-003 Ports SHALL be exactly:
- adc_clk  in  1  sole clock; all logic on its rising edge.
- adc_rst  in  1  reset, asynchronous, active-high.
- adc_valid  in  1  qualifies adc_data for one beat.
- adc_data  in  DATA_PATH_WIDTH*16  received beat; sample 0 in [15:0]; sample 0 is earliest.
- adc_pnseq_sel  in  1  0 = PN9, 1 = PN23.
- adc_pn_err_clr  in  1  synchronous clear of adc_pn_err_cnt.
- adc_pn_oos  out  1  1 = out of sync.
- adc_pn_err  out  1  one-cycle pulse on a mismatched beat while locked.
- adc_pn_err_cnt  out  32  saturating count of mismatched beats while locked.

Function
REQ-004 The bit stream SHALL be serial, MSB first, within each sample, with samples in index order; a beat carries DATA_PATH_WIDTH*16 consecutive PN bits.
REQ-005 The PN sequences SHALL be: PN9 x^9+x^5+1; PN23 x^23+x^18+1 (ITU-T O.150), with output bits uninverted.
REQ-006 The expected beat SHALL be the next DATA_PATH_WIDTH*16 sequence bits, continuing from a seed made of the last 9 or 23 bits of the seed beat.
- Seed beat when in OOS state: the previous received valid beat.
- Seed beat when in LOCKED state: the previous expected beat.
REQ-007 Beats with adc_valid=0 SHALL be ignored; no pipeline, state or counter change occurs for them.
REQ-008 A valid beat SHALL match only if received equals expected and the received beat is not all-zero; an all-zero beat is always a mismatch.
REQ-009 Pipeline: stage 1 SHALL register the match flag; stage 2 SHALL update state, counters and outputs; outputs reflect a valid beat 2 adc_clk cycles after it is accepted.
REQ-010 State machine SHALL be OOS -> LOCKED -> OOS:
- In OOS, a run counter counts consecutive matches and clears on a mismatch; OOS moves to LOCKED when the count reaches OOS_THRESHOLD.
- In LOCKED, the run counter counts consecutive mismatches and clears on a match; LOCKED moves to OOS when the count reaches OOS_THRESHOLD.
- The run counter SHALL clear on every state transition.
REQ-011 adc_pn_oos SHALL be 1 exactly when the state is OOS.
REQ-012 Error reporting SHALL be:
- adc_pn_err pulses for each mismatched beat processed in LOCKED, including the beat that causes the move to OOS.
- adc_pn_err_cnt increments by the same rule and holds at 0xFFFFFFFF.
REQ-013 If adc_pn_err_clr and an increment occur in the same cycle, adc_pn_err_cnt SHALL become 0.
REQ-014 A change of adc_pnseq_sel SHALL, on the next cycle:
- force OOS;
- clear the run counter and the stage-1 flag;
- leave adc_pn_err_cnt unchanged.
- The first valid beat after the change only reseeds and SHALL NOT count as a match.
REQ-015 In OOS, the first valid beat after reset SHALL only seed and SHALL NOT count as a match.

Reset
REQ-016 adc_rst SHALL asynchronously clear all state, at any time including mid-lock, to these values:
- state OOS, adc_pn_oos=1;
- adc_pn_err=0, adc_pn_err_cnt=0;
- run counter 0, pipeline flags 0, seed register 0.
REQ-017 Release of adc_rst SHALL be used as-is; an external synchronizer provides the deassertion synchronization.

Structure
REQ-018 A shared package SHALL hold:
- the PN9/PN23 widths and tap constants;
- the state encoding (OOS=0, LOCKED=1);
- the error-count saturation value.
REQ-019 One combinational sub-module, axi_adc_jesd204_pnstep, SHALL compute the expected beat from seed and pnseq_sel; the top SHALL contain the pipeline, state machine and counters.

Verification
REQ-020 Required bench scenarios:
- Clean PN9 lock: PN9 from seed 0x1FF, DATA_PATH_WIDTH=4, continuous valid -> adc_pn_oos falls 2 cycles after beat 17 (1 seed + 16 matches); adc_pn_err_cnt=0.
- Single error: once locked, flip bit 0 of one beat -> exactly one adc_pn_err pulse; adc_pn_err_cnt=1; adc_pn_oos stays 0; the next correct beat matches.
- Loss of sync: once locked, feed 16 random beats -> adc_pn_oos=1 after the 16th; adc_pn_err_cnt=16.
- All-zero and gaps: all-zero data never locks; PN23 with adc_valid toggling 1/0 locks after 17 valid beats.
- Boundaries: clear collision, preload 0xFFFFFFFE then 3 errors -> 0xFFFFFFFF; adc_pn_err_clr with an error -> 0. adc_pnseq_sel toggle -> OOS next cycle.
- Async reset: assert adc_rst mid-lock between clock edges -> outputs reset immediately, before the next edge.
